// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle: memory-port activity, stall
// sources and ROB occupancy in; per-stage stall/flush and status out.
interface hazard_controller_if #(
  parameter int NUM_STAGES    = 4,
  parameter int NUM_MEM_PORTS = 2,
  parameter int ROB_SIZE      = 16
);
  localparam int ROB_W = $clog2(ROB_SIZE + 1);

  logic [NUM_MEM_PORTS-1:0] mem_req;
  logic [NUM_MEM_PORTS-1:0] mem_resp;
  logic [NUM_MEM_PORTS-1:0] mem_busy;
  logic [NUM_STAGES-1:0]    stage_hold;
  logic [ROB_W-1:0]         rob_count;
  logic                     flush_req;
  logic [NUM_STAGES-1:0]    stall;
  logic [NUM_STAGES-1:0]    flush;
  logic                     redirect;
  logic                     throttle;
  logic [1:0]               fsm_state;
  logic                     err;

  modport master (
    output mem_req, mem_resp, mem_busy, stage_hold, rob_count, flush_req,
    input  stall, flush, redirect, throttle, fsm_state, err
  );

  modport slave (
    input  mem_req, mem_resp, mem_busy, stage_hold, rob_count, flush_req,
    output stall, flush, redirect, throttle, fsm_state, err
  );
endinterface

// File: rtl/hazard_controller.sv
// Per-stage stall/flush controller: outstanding-request counters, ROB
// throttle with hysteresis, mispredict drain/flush/recover sequencing.
module hazard_controller #(
  parameter int NUM_STAGES    = 4,
  parameter int NUM_MEM_PORTS = 2,
  parameter logic [NUM_MEM_PORTS*NUM_STAGES-1:0] PORT_STAGE_MASK = 'h41,
  parameter int CNT_W         = 4,
  parameter int ROB_SIZE      = 16,
  parameter int ROB_HI_WM     = 14,
  parameter int ROB_LO_WM     = 10,
  parameter logic [NUM_STAGES-1:0] ROB_STALL_MASK = 'b0011,
  parameter int FLUSH_CYCLES  = 3
) (
  input logic                clk,
  input logic                reset,
  hazard_controller_if.slave bus
);
  localparam int ROB_W = $clog2(ROB_SIZE + 1);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_MAX    = '1;
  localparam logic [NUM_STAGES-1:0] FLUSH_MASK = {1'b0, {(NUM_STAGES-1){1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2, RECOVER = 2'd3} state_e;

  logic [CNT_W-1:0]         cnt_q [NUM_MEM_PORTS];
  logic [CNT_W-1:0]         cnt_d [NUM_MEM_PORTS];
  logic                     err_q, err_d;
  logic                     thr_q, thr_d;
  state_e                   state_q, state_d;
  logic [FC_W-1:0]          fcnt_q, fcnt_d;
  logic [NUM_MEM_PORTS-1:0] pending;
  logic [NUM_STAGES-1:0]    local_stall;
  logic [NUM_STAGES-1:0]    stall_c;
  logic                     bp;

  // Request + response in the same cycle cancel; errors saturate rather than wrap.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_MEM_PORTS; i++) begin
      pending[i] = (cnt_q[i] != '0) | bus.mem_busy[i];
      cnt_d[i]   = cnt_q[i];
      if (bus.mem_req[i] && !bus.mem_resp[i]) begin
        if (cnt_q[i] == CNT_MAX) err_d = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (bus.mem_resp[i] && !bus.mem_req[i]) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    thr_d = thr_q;
    if (bus.rob_count >= ROB_W'(ROB_HI_WM))      thr_d = 1'b1;
    else if (bus.rob_count <= ROB_W'(ROB_LO_WM)) thr_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE:    if (bus.flush_req) state_d = DRAIN;
      DRAIN: begin
        if (pending == '0) begin
          state_d = FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = RECOVER;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_MEM_PORTS; i++) cnt_q[i] <= '0;
      err_q   <= 1'b0;
      thr_q   <= 1'b0;
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      thr_q   <= thr_d;
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Walk from retire toward fetch so any later stall back-pressures earlier stages.
  always_comb begin
    bp = reset;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      local_stall[k] = bus.stage_hold[k] | (thr_q & ROB_STALL_MASK[k])
                     | ((state_q != IDLE) && (k != NUM_STAGES - 1));
      for (int i = 0; i < NUM_MEM_PORTS; i++)
        local_stall[k] = local_stall[k] | (pending[i] & PORT_STAGE_MASK[i*NUM_STAGES + k]);
      bp         = bp | local_stall[k];
      stall_c[k] = bp;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.flush     = (!reset && state_q == FLUSH) ? FLUSH_MASK : '0;
  assign bus.redirect  = !reset && (state_q == RECOVER);
  assign bus.throttle  = !reset && thr_q;
  assign bus.fsm_state = reset ? IDLE : state_q;
  assign bus.err       = !reset && err_q;
endmodule
